// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - serial frame receiver: start, 4 data bits LSB first, optional even parity, stop
module sipo_frame_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       bit_en,
  input  logic       par_en,
  input  logic       dout_ready,
  output logic [3:0] dout,
  output logic       dout_valid,
  output logic       par_err,
  output logic       frm_err,
  output logic       ovr_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_cnt;
  logic [3:0] r_shift;
  logic       r_par_en;
  logic       r_perr;
  logic [3:0] r_dout;
  logic       r_dout_valid;
  logic       r_par_err;
  logic       r_frm_err;
  logic       r_ovr_err;
  logic       w_load;
  logic       w_frm;
  logic       w_ovr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Output is free when empty or being drained in this very cycle.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_frm        = 1'b0;
    w_ovr        = 1'b0;
    if (bit_en) begin
      case (r_state)
        IDLE: begin
          if (!din) w_state_next = DATA;
        end
        DATA: begin
          if (r_cnt == 2'd3) w_state_next = r_par_en ? PARITY : STOP;
        end
        PARITY: begin
          w_state_next = STOP;
        end
        STOP: begin
          w_state_next = IDLE;
          if (!din) begin
            w_frm = 1'b1;
          end else if (!r_dout_valid || dout_ready) begin
            w_load = 1'b1;
          end else begin
            w_ovr = 1'b1;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= 2'd0;
      r_shift      <= 4'd0;
      r_par_en     <= 1'b0;
      r_perr       <= 1'b0;
      r_dout       <= 4'd0;
      r_dout_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_frm_err    <= 1'b0;
      r_ovr_err    <= 1'b0;
    end else begin
      r_frm_err <= w_frm;
      r_ovr_err <= w_ovr;
      if (bit_en) begin
        case (r_state)
          IDLE: begin
            if (!din) begin
              r_par_en <= par_en;
              r_cnt    <= 2'd0;
              r_perr   <= 1'b0;
            end
          end
          DATA: begin
            r_shift <= {din, r_shift[3:1]};
            r_cnt   <= r_cnt + 2'd1;
          end
          PARITY: begin
            r_perr <= (^r_shift) ^ din;
          end
          default: begin
          end
        endcase
      end
      if (w_load) begin
        r_dout       <= r_shift;
        r_par_err    <= r_par_en & r_perr;
        r_dout_valid <= 1'b1;
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign par_err    = r_par_err;
  assign frm_err    = r_frm_err;
  assign ovr_err    = r_ovr_err;
  assign busy       = (r_state != IDLE);

endmodule

// File: doc/sipo_frame_ctrl.md
SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high; ports named clk and rst.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: din  input  1  serial line; idle level 1.
REQ-005 SHALL have port: bit_en  input  1  bit strobe; din is sampled only on clk edges where bit_en=1.
REQ-006 SHALL have port: par_en  input  1  config; 1 = frame carries an even-parity bit.
REQ-007 SHALL have port: dout_ready  input  1  consumer accepts word when 1 with dout_valid=1.
REQ-008 SHALL have port: dout  output  4  received data word; bit 0 = first data bit on the line.
REQ-009 SHALL have port: dout_valid  output  1  dout holds an unconsumed word.
REQ-010 SHALL have port: par_err  output  1  parity mismatch flag for the word on dout; valid only while dout_valid=1.
REQ-011 SHALL have port: frm_err  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-012 SHALL have port: ovr_err  output  1  one-cycle pulse: completed frame dropped because output was full.
REQ-013 SHALL have port: busy  output  1  1 whenever state is not IDLE.

Function
REQ-014 SHALL implement a frame of: start bit 0, 4 data bits LSB first, parity bit only if par_en=1, stop bit 1.
REQ-015 SHALL use states IDLE, DATA, PARITY, STOP; all transitions occur only on edges with bit_en=1.
REQ-016 SHALL go IDLE->DATA when din=0 sampled in IDLE; din=1 in IDLE: stay IDLE.
REQ-017 SHALL latch par_en at the start-bit sample and use the latched value for the rest of that frame.
REQ-018 SHALL, in DATA, shift right into a 4-bit internal shift register (din into bit 3) and increment a 2-bit bit counter per sample; after the 4th sample (counter wraps 3->0), go to PARITY if latched par_en=1, else STOP.
REQ-019 SHALL, in PARITY, compute err = XOR(4 data bits, din) (even parity; err=1 on mismatch); go to STOP.
REQ-020 SHALL, in STOP, return to IDLE regardless of din value.
REQ-021 SHALL, on stop sample din=0, pulse frm_err for exactly the next cycle and discard the word (dout, dout_valid unchanged).
REQ-022 SHALL, on stop sample din=1 with output free, load dout and par_err and set dout_valid on the next cycle (1 clk latency after stop sample).
REQ-023 SHALL define output free as dout_valid=0, or dout_valid=1 and dout_ready=1 in the same cycle as the stop sample (simultaneous accept and load: new word loads, no overrun).
REQ-024 SHALL, on stop sample din=1 with output not free, drop the word, pulse ovr_err for the next cycle, keep old dout/par_err/dout_valid.
REQ-025 SHALL clear dout_valid the cycle after dout_valid=1 and dout_ready=1, unless a new word loads per REQ-023.
REQ-026 SHALL hold dout and par_err stable while dout_valid=1 and dout_ready=0.
REQ-027 SHALL set par_err=0 when loading a word from a frame with latched par_en=0.
REQ-028 SHALL ignore din, dout_ready-independent state progress, and bit_en=0 cycles: no state, counter or shift change when bit_en=0.
REQ-029 SHALL treat back-to-back frames (start bit immediately after stop sample) as normal: IDLE accepts start on the very next bit_en.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, force state IDLE, bit counter 0, shift register 0, latched par_en 0.
REQ-031 SHALL, on reset, drive dout=4'b0000, dout_valid=0, par_err=0, frm_err=0, ovr_err=0, busy=0 from the next cycle.
REQ-032 SHALL, on reset mid-frame, abandon the frame with no output, error pulse or partial word.
REQ-033 SHALL give rst priority over all other inputs including bit_en and dout_ready.

Verification
REQ-034 SHALL cover: par_en=0, bit_en=1 each cycle, din 0,1,0,1,1,1 (start, data 1,0,1,1, stop), dout_ready=0 -> dout=4'b1101, dout_valid=1 one cycle after stop, par_err=0, held until dout_ready=1.
REQ-035 SHALL cover: par_en=1, data 1,1,0,0, parity bit 1 -> dout=4'b0011, par_err=1; repeat with parity bit 0 -> par_err=0.
REQ-036 SHALL cover: stop bit sampled 0 -> frm_err one-cycle pulse, dout_valid stays 0, next valid frame received normally.
REQ-037 SHALL cover: second frame completes with dout_valid=1, dout_ready=0 -> ovr_err pulse, dout keeps first word; repeat with dout_ready=1 on stop-sample cycle -> no ovr_err, second word on dout.
REQ-038 SHALL cover: bit_en=1 every 3rd cycle -> identical result to REQ-034; then rst=1 after 2 data bits -> busy=0, all outputs 0, no error pulse.
